sal_cmd_sched: RTL

SAL_CMD_SCHED -- requirements
Module: sal_cmd_sched

---
 rtl/sal_cmd_sched.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/sal_cmd_sched.sv
// sal_cmd_sched: round-robin DDR2 command-bus scheduler for NUM_BANKS bank controllers with tFAW tracking.
// Build option SAL_CMD_SCHED_COL_PRIO_EN: eligible RD/WR requests win over ACT/PRE/REF.
module sal_cmd_sched #(
   parameter int NUM_BANKS  = 4,
   parameter int BA_WIDTH   = 2,
   parameter int ADDR_WIDTH = 13
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [5:0]                       t_faw_i,
   input  logic [NUM_BANKS-1:0]             req_valid_i,
   input  logic [3*NUM_BANKS-1:0]           req_cmd_i,
   input  logic [ADDR_WIDTH*NUM_BANKS-1:0]  req_addr_i,
   output logic [NUM_BANKS-1:0]             req_gnt_o,
   output logic                             cmd_cs_n_o,
   output logic                             cmd_ras_n_o,
   output logic                             cmd_cas_n_o,
   output logic                             cmd_we_n_o,
   output logic [BA_WIDTH-1:0]              cmd_ba_o,
   output logic [ADDR_WIDTH-1:0]            cmd_addr_o
);

   localparam logic [2:0] CMD_ACT = 3'd0;
   localparam logic [2:0] CMD_RD  = 3'd1;
   localparam logic [2:0] CMD_WR  = 3'd2;
   localparam logic [2:0] CMD_PRE = 3'd3;
   localparam logic [2:0] CMD_REF = 3'd4;

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] PINS_ACT   = 4'b0011;
   localparam logic [3:0] PINS_RD    = 4'b0101;
   localparam logic [3:0] PINS_WR    = 4'b0100;
   localparam logic [3:0] PINS_PRE   = 4'b0010;
   localparam logic [3:0] PINS_REF   = 4'b0001;
   localparam logic [3:0] PINS_NOP   = 4'b0111;
   localparam logic [3:0] PINS_DESEL = 4'b1111;

   localparam int FAW_SLOTS = 4;

   function automatic logic [3:0] encode_pins(input logic [2:0] code);
      logic [3:0] pins;
      case (code)
         CMD_ACT: pins = PINS_ACT;
         CMD_RD:  pins = PINS_RD;
         CMD_WR:  pins = PINS_WR;
         CMD_PRE: pins = PINS_PRE;
         CMD_REF: pins = PINS_REF;
         default: pins = PINS_NOP;
      endcase
      return pins;
   endfunction

   // Column commands never request auto-precharge, so A10 is forced low.
   function automatic logic [ADDR_WIDTH-1:0] encode_addr(input logic [2:0] code,
                                                         input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH-1:0] ap_mask;
      logic [ADDR_WIDTH-1:0] result;
      ap_mask = ~(ADDR_WIDTH'(1'b1) << 4'd10);
      case (code)
         CMD_ACT: result = addr;
         CMD_RD:  result = addr & ap_mask;
         CMD_WR:  result = addr & ap_mask;
         default: result = '0;
      endcase
      return result;
   endfunction

   logic [BA_WIDTH-1:0]   rr_ptr_r;
   logic [5:0]            faw_cnt_r [FAW_SLOTS];
   logic [3:0]            pins_r;
   logic [BA_WIDTH-1:0]   ba_r;
   logic [ADDR_WIDTH-1:0] addr_r;

   logic                  faw_block_s;
   logic [NUM_BANKS-1:0]  elig_s;
   logic [NUM_BANKS-1:0]  cand_s;
   logic [NUM_BANKS-1:0]  gnt_s;
   logic                  gnt_any_s;
   logic                  gnt_fire_s;
   logic [BA_WIDTH-1:0]   gnt_idx_s;
   logic [BA_WIDTH-1:0]   next_ptr_s;
   logic [2:0]            gnt_code_s;
   logic [ADDR_WIDTH-1:0] gnt_addr_s;
   logic                  act_gnt_s;
   logic [FAW_SLOTS-1:0]  faw_load_s;
   logic                  faw_found_s;
   logic [5:0]            faw_load_val_s;
   int                    pos_s;

   // ACTs are blocked only while every tFAW slot is still counting.
   always_comb begin
      faw_block_s = 1'b1;
      for (int k = 0; k < FAW_SLOTS; k++) begin
         faw_block_s = faw_block_s && (faw_cnt_r[k] != 6'd0);
      end
   end

   // Per-bank eligibility: valid, legal code, and not a tFAW-blocked ACT.
   always_comb begin
      elig_s = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         elig_s[b] = req_valid_i[b]
                  && (req_cmd_i[3*b +: 3] <= CMD_REF)
                  && !((req_cmd_i[3*b +: 3] == CMD_ACT) && faw_block_s);
      end
   end

`ifdef SAL_CMD_SCHED_COL_PRIO_EN
   logic [NUM_BANKS-1:0] col_s;

   // Column commands form the winning class whenever any is eligible.
   always_comb begin
      col_s = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         col_s[b] = elig_s[b]
                 && ((req_cmd_i[3*b +: 3] == CMD_RD) || (req_cmd_i[3*b +: 3] == CMD_WR));
      end
      if (col_s != '0) begin
         cand_s = col_s;
      end else begin
         cand_s = elig_s;
      end
   end
`else
   // Pure round-robin over every eligible request.
   always_comb begin
      cand_s = elig_s;
   end
`endif

   // Round-robin search starting at rr_ptr; grants are suppressed in reset.
   always_comb begin
      gnt_any_s = 1'b0;
      gnt_idx_s = '0;
      pos_s     = 0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         pos_s = (int'(rr_ptr_r) + i) % NUM_BANKS;
         if (!gnt_any_s && cand_s[pos_s]) begin
            gnt_any_s = 1'b1;
            gnt_idx_s = BA_WIDTH'(pos_s);
         end else begin
            gnt_any_s = gnt_any_s;
         end
      end
      gnt_fire_s = gnt_any_s && rst_n;
      gnt_s      = '0;
      if (gnt_fire_s) begin
         gnt_s[gnt_idx_s] = 1'b1;
      end else begin
         gnt_s = '0;
      end
      next_ptr_s = BA_WIDTH'((int'(gnt_idx_s) + 1) % NUM_BANKS);
      gnt_code_s = req_cmd_i[3*gnt_idx_s +: 3];
      gnt_addr_s = req_addr_i[ADDR_WIDTH*gnt_idx_s +: ADDR_WIDTH];
      act_gnt_s  = gnt_fire_s && (gnt_code_s == CMD_ACT);
   end

   // An ACT grant loads the lowest idle tFAW slot; 0 and 1 disable the window.
   always_comb begin
      faw_load_s     = '0;
      faw_found_s    = 1'b0;
      faw_load_val_s = (t_faw_i > 6'd1) ? (t_faw_i - 6'd1) : 6'd0;
      for (int k = 0; k < FAW_SLOTS; k++) begin
         if (act_gnt_s && !faw_found_s && (faw_cnt_r[k] == 6'd0)) begin
            faw_load_s[k] = 1'b1;
            faw_found_s   = 1'b1;
         end else begin
            faw_load_s[k] = 1'b0;
         end
      end
   end

   // Round-robin pointer moves past the bank just granted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_r <= '0;
      end else if (gnt_fire_s) begin
         rr_ptr_r <= next_ptr_s;
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end

   // tFAW slots count down to 0 every cycle, independent of other slots loading.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < FAW_SLOTS; k++) begin
            faw_cnt_r[k] <= 6'd0;
         end
      end else begin
         for (int k = 0; k < FAW_SLOTS; k++) begin
            if (faw_load_s[k]) begin
               faw_cnt_r[k] <= faw_load_val_s;
            end else if (faw_cnt_r[k] != 6'd0) begin
               faw_cnt_r[k] <= faw_cnt_r[k] - 6'd1;
            end else begin
               faw_cnt_r[k] <= faw_cnt_r[k];
            end
         end
      end
   end

   // Command pins: granted command one cycle later, NOP otherwise, deselect in reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pins_r <= PINS_DESEL;
         ba_r   <= '0;
         addr_r <= '0;
      end else if (gnt_fire_s) begin
         pins_r <= encode_pins(gnt_code_s);
         ba_r   <= gnt_idx_s;
         addr_r <= encode_addr(gnt_code_s, gnt_addr_s);
      end else begin
         pins_r <= PINS_NOP;
         ba_r   <= '0;
         addr_r <= '0;
      end
   end

   assign req_gnt_o   = gnt_s;
   assign cmd_cs_n_o  = pins_r[3];
   assign cmd_ras_n_o = pins_r[2];
   assign cmd_cas_n_o = pins_r[1];
   assign cmd_we_n_o  = pins_r[0];
   assign cmd_ba_o    = ba_r;
   assign cmd_addr_o  = addr_r;

endmodule
